// File: rtl/down_counter_pkg.sv
// Shared constants for the push-button down counter.
// LED bit positions are named here so the up counter can reuse them.
package down_counter_pkg;

  localparam int LEDR_UF   = 0;
  localparam int LEDR_ZERO = 1;

  localparam int DB_MIN_CYCLES = 2;

endpackage

// File: rtl/down_counter_button_debounce.sv
// Two-flop synchronizer, stable-sample debouncer and press detector.
// Reusable for any active-low board push-button.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic CLOCK_50,
  input  logic rst_n,
  input  logic btn_n_async,
  output logic btn_db,
  output logic press
);
  import down_counter_pkg::*;

  localparam int CW =
    (DEBOUNCE_CYCLES < DB_MIN_CYCLES)
      ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST =
    CW'(DEBOUNCE_CYCLES - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_db;
  logic          r_db_d;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      r_s1   <= 1'b1;
      r_s2   <= 1'b1;
      r_db   <= 1'b1;
      r_db_d <= 1'b1;
      r_cnt  <= '0;
    end else begin
      r_s1   <= btn_n_async;
      r_s2   <= r_s1;
      r_db_d <= r_db;
      if (r_s2 == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        r_db  <= r_s2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign btn_db = r_db;
  // Falling edge of the debounced level only.
  assign press  = r_db_d & ~r_db;

endmodule

// File: rtl/down_counter.sv
// Board-level down counter: KEY[1] decrements, SW loads a preset,
// LEDG shows the count, LEDR flags sticky underflow and zero.
module down_counter #(
  parameter int               WIDTH           = 4,
  parameter int               DEBOUNCE_CYCLES = 500000,
  parameter logic [WIDTH-1:0] RESET_VALUE     = 4'hF
) (
  input  logic             CLOCK_50,
  input  logic [1:0]       KEY,
  input  logic [WIDTH:0]   SW,
  output logic [WIDTH-1:0] LEDG,
  output logic [1:0]       LEDR
);
  import down_counter_pkg::*;

  logic             w_rst_n;
  logic             w_press;
  logic             w_btn_db;
  logic             w_dec;
  logic             w_load;
  logic [WIDTH-1:0] w_load_val;

  logic [WIDTH:0]   r_sw_s1;
  logic [WIDTH:0]   r_sw_s2;
  logic [WIDTH-1:0] r_count;
  logic             r_uf;

  assign w_rst_n = KEY[0];

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key1 (
    .CLOCK_50   (CLOCK_50),
    .rst_n      (w_rst_n),
    .btn_n_async(KEY[1]),
    .btn_db     (w_btn_db),
    .press      (w_press)
  );

  // A press pulse always coincides with a low debounced level.
  assign w_dec      = w_press & ~w_btn_db;
  assign w_load     = r_sw_s2[WIDTH];
  assign w_load_val = r_sw_s2[WIDTH-1:0];

  always_ff @(posedge CLOCK_50) begin
    if (!w_rst_n) begin
      r_sw_s1 <= '0;
      r_sw_s2 <= '0;
      r_count <= RESET_VALUE;
      r_uf    <= 1'b0;
    end else begin
      r_sw_s1 <= SW;
      r_sw_s2 <= r_sw_s1;
      if (w_load) begin
        r_count <= w_load_val;
      end else if (w_dec) begin
        r_count <= r_count - WIDTH'(1);
        if (r_count == '0) begin
          r_uf <= 1'b1;
        end
      end
    end
  end

  assign LEDG            = r_count;
  assign LEDR[LEDR_UF]   = r_uf;
  assign LEDR[LEDR_ZERO] = (r_count == '0);

endmodule

// File: tb/tb_down_counter.sv
// Directed bench for down_counter with a short debounce window.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_down_counter;

  logic       clk;
  logic [1:0] key;
  logic [4:0] sw;
  logic [3:0] ledg;
  logic [1:0] ledr;

  int n_checks;
  int n_fail;

  down_counter #(
    .WIDTH          (4),
    .DEBOUNCE_CYCLES(4),
    .RESET_VALUE    (4'hF)
  ) dut (
    .CLOCK_50(clk),
    .KEY     (key),
    .SW      (sw),
    .LEDG    (ledg),
    .LEDR    (ledr)
  );

  initial clk = 1'b0;
  always #1 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_press();
    key[1] = 1'b0;
    step(10);
    key[1] = 1'b1;
    step(10);
  endtask

  task automatic test_reset();
    key = 2'b10;
    sw  = '0;
    step(5);
    n_checks++;
    if (ledg !== 4'hF) begin
      n_fail++;
      $display("FAIL reset_ledg: got %h want f", ledg);
    end
    n_checks++;
    if (ledr !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_ledr: got %b want 00", ledr);
    end
    key = 2'b11;
    step(3);
  endtask

  task automatic test_single_press();
    key[1] = 1'b0;
    step(6);
    n_checks++;
    if (ledg !== 4'hF) begin
      n_fail++;
      $display("FAIL press_early: got %h want f", ledg);
    end
    step(1);
    n_checks++;
    if (ledg !== 4'hE) begin
      n_fail++;
      $display("FAIL press_edge6: got %h want e", ledg);
    end
    step(13);
    n_checks++;
    if (ledg !== 4'hE) begin
      n_fail++;
      $display("FAIL press_hold: got %h want e", ledg);
    end
    key[1] = 1'b1;
    step(12);
    n_checks++;
    if (ledg !== 4'hE) begin
      n_fail++;
      $display("FAIL press_release: got %h want e", ledg);
    end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 8; i++) begin
      key[1] = i[0];
      step(2);
      n_checks++;
      if (ledg !== 4'hE) begin
        n_fail++;
        $display("FAIL bounce_%0d: got %h want e", i, ledg);
      end
    end
    key[1] = 1'b0;
    step(6);
    n_checks++;
    if (ledg !== 4'hE) begin
      n_fail++;
      $display("FAIL bounce_early: got %h want e", ledg);
    end
    step(1);
    n_checks++;
    if (ledg !== 4'hD) begin
      n_fail++;
      $display("FAIL bounce_dec: got %h want d", ledg);
    end
    key[1] = 1'b1;
    step(12);
    n_checks++;
    if (ledg !== 4'hD) begin
      n_fail++;
      $display("FAIL bounce_once: got %h want d", ledg);
    end
  endtask

  task automatic test_load_wrap();
    sw = 5'b1_0001;
    step(4);
    sw = '0;
    step(6);
    n_checks++;
    if ({ledr, ledg} !== {2'b00, 4'h1}) begin
      n_fail++;
      $display("FAIL load1: got %b/%h want 00/1", ledr, ledg);
    end
    do_press();
    n_checks++;
    if ({ledr, ledg} !== {2'b10, 4'h0}) begin
      n_fail++;
      $display("FAIL to_zero: got %b/%h want 10/0", ledr, ledg);
    end
    do_press();
    n_checks++;
    if ({ledr, ledg} !== {2'b01, 4'hF}) begin
      n_fail++;
      $display("FAIL wrap: got %b/%h want 01/f", ledr, ledg);
    end
    sw = 5'b1_0011;
    step(4);
    sw = '0;
    step(6);
    n_checks++;
    if ({ledr, ledg} !== {2'b01, 4'h3}) begin
      n_fail++;
      $display("FAIL load3_sticky: got %b/%h want 01/3", ledr, ledg);
    end
  endtask

  task automatic test_load_vs_press();
    sw = 5'b1_0111;
    step(4);
    key[1] = 1'b0;
    step(10);
    n_checks++;
    if (ledg !== 4'h7) begin
      n_fail++;
      $display("FAIL load_press: got %h want 7", ledg);
    end
    key[1] = 1'b1;
    step(10);
    sw = '0;
    step(10);
    n_checks++;
    if ({ledr, ledg} !== {2'b01, 4'h7}) begin
      n_fail++;
      $display("FAIL load_after: got %b/%h want 01/7", ledr, ledg);
    end
  endtask

  task automatic test_reset_mid();
    key[1] = 1'b0;
    step(2);
    key = 2'b00;
    step(3);
    n_checks++;
    if ({ledr, ledg} !== {2'b00, 4'hF}) begin
      n_fail++;
      $display("FAIL mid_reset: got %b/%h want 00/f", ledr, ledg);
    end
    key = 2'b01;
    step(6);
    n_checks++;
    if (ledg !== 4'hF) begin
      n_fail++;
      $display("FAIL post_rst_early: got %h want f", ledg);
    end
    step(1);
    n_checks++;
    if ({ledr, ledg} !== {2'b00, 4'hE}) begin
      n_fail++;
      $display("FAIL post_rst_dec: got %b/%h want 00/e", ledr, ledg);
    end
    key = 2'b11;
    step(10);
    n_checks++;
    if (ledg !== 4'hE) begin
      n_fail++;
      $display("FAIL post_rst_rel: got %h want e", ledg);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    key      = 2'b11;
    sw       = '0;
    step(1);
    test_reset();
    test_single_press();
    test_bounce();
    test_load_wrap();
    test_load_vs_press();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/down_counter.md
Name: down_counter

Overview:
- Push-button driven down counter: the counting counterpart to the existing up counter, on the same board I/O (CLOCK_50, KEY, SW, LEDG, LEDR).
- KEY[1] is debounced and edge-detected; each press decrements a WIDTH-bit count shown on LEDG.
- SW loads a preset value. LEDR flags zero and a sticky underflow.
- Sits at board top level, beside the up counter.

Parameters:
- WIDTH, 4, count width; LEDG and SW load-field width.
- DEBOUNCE_CYCLES, 500000, consecutive stable synced samples required before the debounced KEY[1] state changes (10 ms at 50 MHz); minimum 2.
- RESET_VALUE, 4'hF, count value after reset (WIDTH bits).

Ports:
- CLOCK_50  input  1  system clock, 50 MHz, all logic on rising edge.
- KEY  input  2  KEY[0] is the reset: synchronous, active-low, sampled raw with no synchronizer. KEY[1] is the decrement button, active-low and asynchronous.
- SW  input  WIDTH+1  SW[WIDTH-1:0] is the load value. SW[WIDTH] is load enable, level, active-high, asynchronous.
- LEDG  output  WIDTH  current count.
- LEDR  output  2  LEDR[0] is sticky underflow; LEDR[1] is the zero flag.

Behaviour:
- Reset: KEY[0]==0 at an edge, and on every edge while held, sets:
  - KEY[1] synchronizer flops to 1, debounced state db=1, db_d=1, stable counter=0;
  - SW synchronizer flops to 0;
  - count=RESET_VALUE, underflow=0.
  - Therefore LEDG=RESET_VALUE, LEDR[0]=0, LEDR[1]=(RESET_VALUE==0).
- Reset has priority over every other action. Asserting reset mid-debounce discards the pending press. After reset release, a button already held low is seen as a new press once debounce completes.
- Synchronizer: KEY[1] and SW each pass through two flops (s1, s2).
- Debounce:
  - If s2==db, the stable counter is cleared.
  - Otherwise it increments. When it reaches DEBOUNCE_CYCLES-1 with a mismatch still present, db<=s2 and the counter clears.
  - Any bounce back to s2==db before that point clears the counter.
- Edge detect: db_d<=db every cycle; press = db_d & ~db (a 1->0 transition, one cycle wide). Release (0->1) produces no action.
- Latency: let k0 be the first edge that samples KEY[1]=0, with KEY[1] stable from then on. Then s2=0 at k0+1, db flips at k0+1+DEBOUNCE_CYCLES, and count decrements at k0+2+DEBOUNCE_CYCLES.
- Count update, priority high to low:
  1. Reset.
  2. Synced load enable (SW[WIDTH] s2==1): count<=SW[WIDTH-1:0] s2. A press in the same cycle is dropped. Load is level: count tracks the switches while it is held.
  3. press: count<=count-1, modulo 2^WIDTH.
- Wrap-around: a press with count==0 gives count=all ones and sets underflow=1. Underflow is sticky and cleared only by reset; load does not clear it.
- LEDR[1] is combinational (count==0). LEDG, LEDR[0] and the count are registered outputs.
- Holding KEY[1] produces exactly one decrement. There is no auto-repeat.

Decomposition:
- No shared package needed; WIDTH, DEBOUNCE_CYCLES and RESET_VALUE are module parameters.
- One sub-module is natural: button_debounce (parameter DEBOUNCE_CYCLES; ports CLOCK_50, rst_n, btn_n_async, btn_db, press).
  - It contains the 2-flop synchronizer, stable counter, db/db_d and press pulse.
  - It is reusable by the up counter and for KEY[2..3] on later boards.
  - Counter width is clog2(DEBOUNCE_CYCLES).
- The SW synchronizer stays inline.

Test Plan:
- Bench config: DEBOUNCE_CYCLES=4, 2-time-unit clock, KEY=2'b11, SW=0. Apply reset by holding KEY[0]=0 for 5 edges -> LEDG=4'hF, LEDR=2'b00.
- Single clean press: KEY[1]=0 for 20 cycles, then 1 -> LEDG=4'hE exactly 6 edges after k0. No change on release. LEDG stays 4'hE.
- Bounce: KEY[1] toggles 0/1 every 2 cycles for 16 cycles, then held 0 -> LEDG unchanged during bouncing; exactly one decrement, 6 edges after the final stable low.
- Load and wrap: SW=5'b1_0001 for 4 cycles, then SW=0 -> LEDG=4'h1. Press -> LEDG=0, LEDR=2'b10. Press -> LEDG=4'hF, LEDR=2'b01. Load 4'h3 -> LEDG=3, LEDR[0] still 1.
- Load vs press: SW[4]=1 with value 4'h7 held across the press pulse cycle -> LEDG=7 with no decrement. Deasserting load afterwards causes no delayed decrement.
- Reset mid-operation: drive KEY[0]=0 2 cycles into a debounce, and again while LEDR[0]=1 -> LEDG=4'hF, LEDR=2'b00. With KEY[1] still low after release, one decrement occurs 6 edges later -> LEDG=4'hE.
